// File: rtl/uart_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// uart_fifo_ctrl
//   Full-duplex UART with a TX FIFO feeding a transmit bit engine and an RX bit
//   engine feeding an RX FIFO. Character width, parity mode, stop bits, line
//   rate and FIFO depth are parameters. RX entries carry per-character parity
//   and framing error flags; a sticky overrun flag records characters dropped
//   because the RX FIFO was full.
//
// Ports
//   sys_clk, rst_n          clock (rising edge), asynchronous active-low reset
//   uart_rx / uart_tx       serial line in (asynchronous) / out (idles high)
//   tx_wr_en, tx_data_in    push a character into the TX FIFO
//   tx_full, tx_level       TX FIFO full flag and fill level
//   tx_busy                 high from start bit through last stop bit
//   rx_rd_en                pop the RX FIFO head
//   rx_data_out             RX FIFO head data (valid while !rx_empty)
//   rx_parity_err           parity error flag of head entry
//   rx_frame_err            framing error flag of head entry
//   rx_empty, rx_level      RX FIFO empty flag and fill level
//   rx_overrun, clr_overrun sticky drop flag and its clear (new overrun wins)
// -----------------------------------------------------------------------------

// Synchronous FIFO with registered level/full/empty and show-ahead head.
module uart_fifo_sync #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   level_r;
  logic          full_r;
  logic          empty_r;
  logic          wr_ok_s;
  logic          rd_ok_s;
  logic [AW:0]   level_nxt_s;

  // Accept/reject decisions use the pre-edge flags; next fill level.
  always_comb begin
    wr_ok_s     = wr_en & ~full_r;
    rd_ok_s     = rd_en & ~empty_r;
    level_nxt_s = level_r;
    if (wr_ok_s && !rd_ok_s) begin
      level_nxt_s = level_r + 1'b1;
    end else if (!wr_ok_s && rd_ok_s) begin
      level_nxt_s = level_r - 1'b1;
    end else begin
      level_nxt_s = level_r;
    end
  end

  // Storage, pointers and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (wr_ok_s) begin
        mem_r[wr_ptr_r] <= wr_data;
        wr_ptr_r        <= wr_ptr_r + 1'b1;
      end
      if (rd_ok_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      level_r <= level_nxt_s;
      full_r  <= (level_nxt_s == FULL_LVL);
      empty_r <= (level_nxt_s == '0);
    end
  end

  assign rd_data = mem_r[rd_ptr_r];
  assign full    = full_r;
  assign empty   = empty_r;
  assign level   = level_r;
endmodule

module uart_fifo_ctrl #(
  parameter int CLK_FREQ_MHZ    = 200,
  parameter int BAUD_RATE       = 115200,
  parameter int DATA_BITS       = 8,
  parameter int PARITY          = 0,
  parameter int STOP_BITS       = 1,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                     sys_clk,
  input  logic                     rst_n,
  input  logic                     uart_rx,
  output logic                     uart_tx,
  input  logic                     tx_wr_en,
  input  logic [DATA_BITS-1:0]     tx_data_in,
  output logic                     tx_full,
  output logic [FIFO_DEPTH_LOG2:0] tx_level,
  output logic                     tx_busy,
  input  logic                     rx_rd_en,
  output logic [DATA_BITS-1:0]     rx_data_out,
  output logic                     rx_parity_err,
  output logic                     rx_frame_err,
  output logic                     rx_empty,
  output logic [FIFO_DEPTH_LOG2:0] rx_level,
  output logic                     rx_overrun,
  input  logic                     clr_overrun
);
  localparam int AW           = FIFO_DEPTH_LOG2;
  localparam int CLKS_PER_BIT = (CLK_FREQ_MHZ * 1_000_000) / BAUD_RATE;
  localparam int STOP_CLKS    = STOP_BITS * CLKS_PER_BIT;
  localparam int CW           = $clog2(STOP_CLKS + 1);
  localparam int IW           = $clog2(DATA_BITS);
  localparam logic [CW-1:0] BIT_END   = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] STOP_END  = CW'(STOP_CLKS - 1);
  localparam logic [CW-1:0] HALF_END  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] BIT_LAST  = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

  // Parity bit that accompanies a character (0 when parity is disabled).
  function automatic logic calc_parity(input logic [DATA_BITS-1:0] d);
    logic p;
    case (PARITY)
      1:       p = ~^d;
      2:       p = ^d;
      default: p = 1'b0;
    endcase
    return p;
  endfunction

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

  // ---------------------------------------------------------------- TX path
  logic                 tx_empty_s;
  logic [DATA_BITS-1:0] tx_head_s;
  logic                 tx_pop_s;
  tx_state_t            tx_state_r, tx_state_s;
  logic [CW-1:0]        tx_cnt_r, tx_cnt_s;
  logic [IW-1:0]        tx_idx_r, tx_idx_s;
  logic [DATA_BITS-1:0] tx_shift_r, tx_shift_s;
  logic                 tx_par_r, tx_par_s;
  logic                 tx_bit_s;
  logic                 uart_tx_r;
  logic                 tx_busy_r;

  uart_fifo_sync #(.W(DATA_BITS), .AW(AW)) u_tx_fifo (
    .clk     (sys_clk),
    .rst_n   (rst_n),
    .wr_en   (tx_wr_en),
    .wr_data (tx_data_in),
    .rd_en   (tx_pop_s),
    .rd_data (tx_head_s),
    .full    (tx_full),
    .empty   (tx_empty_s),
    .level   (tx_level)
  );

  // TX next-state: the end of a stop period chains straight into the next
  // start bit when more data is queued, so back-to-back frames have no gap.
  always_comb begin
    tx_state_s = tx_state_r;
    tx_cnt_s   = tx_cnt_r + 1'b1;
    tx_idx_s   = tx_idx_r;
    tx_shift_s = tx_shift_r;
    tx_par_s   = tx_par_r;
    tx_pop_s   = 1'b0;
    tx_bit_s   = 1'b1;
    case (tx_state_r)
      TX_IDLE: begin
        tx_bit_s = 1'b1;
        tx_cnt_s = '0;
        if (!tx_empty_s) begin
          tx_pop_s   = 1'b1;
          tx_shift_s = tx_head_s;
          tx_par_s   = calc_parity(tx_head_s);
          tx_state_s = TX_START;
        end else begin
          tx_state_s = TX_IDLE;
        end
      end
      TX_START: begin
        tx_bit_s = 1'b0;
        if (tx_cnt_r == BIT_END) begin
          tx_cnt_s   = '0;
          tx_idx_s   = '0;
          tx_state_s = TX_DATA;
        end else begin
          tx_state_s = TX_START;
        end
      end
      TX_DATA: begin
        tx_bit_s = tx_shift_r[0];
        if (tx_cnt_r == BIT_END) begin
          tx_cnt_s = '0;
          if (tx_idx_r == BIT_LAST) begin
            tx_state_s = (PARITY != 0) ? TX_PARITY : TX_STOP;
          end else begin
            tx_idx_s   = tx_idx_r + 1'b1;
            tx_shift_s = {1'b0, tx_shift_r[DATA_BITS-1:1]};
          end
        end else begin
          tx_state_s = TX_DATA;
        end
      end
      TX_PARITY: begin
        tx_bit_s = tx_par_r;
        if (tx_cnt_r == BIT_END) begin
          tx_cnt_s   = '0;
          tx_state_s = TX_STOP;
        end else begin
          tx_state_s = TX_PARITY;
        end
      end
      TX_STOP: begin
        tx_bit_s = 1'b1;
        if (tx_cnt_r == STOP_END) begin
          tx_cnt_s = '0;
          if (!tx_empty_s) begin
            tx_pop_s   = 1'b1;
            tx_shift_s = tx_head_s;
            tx_par_s   = calc_parity(tx_head_s);
            tx_state_s = TX_START;
          end else begin
            tx_state_s = TX_IDLE;
          end
        end else begin
          tx_state_s = TX_STOP;
        end
      end
      default: begin
        tx_cnt_s   = '0;
        tx_state_s = TX_IDLE;
      end
    endcase
  end

  // TX state register; the line and busy flag are registered from the
  // current state, so both lag the state by one cycle uniformly.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_r <= TX_IDLE;
      tx_cnt_r   <= '0;
      tx_idx_r   <= '0;
      tx_shift_r <= '0;
      tx_par_r   <= 1'b0;
      uart_tx_r  <= 1'b1;
      tx_busy_r  <= 1'b0;
    end else begin
      tx_state_r <= tx_state_s;
      tx_cnt_r   <= tx_cnt_s;
      tx_idx_r   <= tx_idx_s;
      tx_shift_r <= tx_shift_s;
      tx_par_r   <= tx_par_s;
      uart_tx_r  <= tx_bit_s;
      tx_busy_r  <= (tx_state_r != TX_IDLE);
    end
  end

  assign uart_tx = uart_tx_r;
  assign tx_busy = tx_busy_r;

  // ---------------------------------------------------------------- RX path
  logic                   rx_sync1_r, rx_sync2_r, rx_prev_r;
  rx_state_t              rx_state_r, rx_state_s;
  logic [CW-1:0]          rx_cnt_r, rx_cnt_s;
  logic [IW-1:0]          rx_idx_r, rx_idx_s;
  logic [DATA_BITS-1:0]   rx_shift_r, rx_shift_s;
  logic                   rx_perr_r, rx_perr_s;
  logic                   rx_ferr_r, rx_ferr_s;
  logic                   rx_push_s;
  logic                   ovr_set_s;
  logic [DATA_BITS+1:0]   rx_entry_s;
  logic [DATA_BITS+1:0]   rx_head_s;
  logic                   rx_full_s;
  logic                   rx_overrun_r;

  uart_fifo_sync #(.W(DATA_BITS + 2), .AW(AW)) u_rx_fifo (
    .clk     (sys_clk),
    .rst_n   (rst_n),
    .wr_en   (rx_push_s),
    .wr_data (rx_entry_s),
    .rd_en   (rx_rd_en),
    .rd_data (rx_head_s),
    .full    (rx_full_s),
    .empty   (rx_empty),
    .level   (rx_level)
  );

  // Two-flop synchroniser plus previous-sample for falling-edge detection.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync1_r <= 1'b1;
      rx_sync2_r <= 1'b1;
      rx_prev_r  <= 1'b1;
    end else begin
      rx_sync1_r <= uart_rx;
      rx_sync2_r <= rx_sync1_r;
      rx_prev_r  <= rx_sync2_r;
    end
  end

  // RX next-state. A start only triggers on a falling edge, so a held-low
  // line after a bad stop bit cannot re-arm until it has returned high.
  always_comb begin
    rx_state_s = rx_state_r;
    rx_cnt_s   = rx_cnt_r + 1'b1;
    rx_idx_s   = rx_idx_r;
    rx_shift_s = rx_shift_r;
    rx_perr_s  = rx_perr_r;
    rx_ferr_s  = rx_ferr_r;
    rx_push_s  = 1'b0;
    ovr_set_s  = 1'b0;
    rx_entry_s = {rx_ferr_r, rx_perr_r, rx_shift_r};
    case (rx_state_r)
      RX_IDLE: begin
        rx_cnt_s = '0;
        if (rx_prev_r && !rx_sync2_r) begin
          rx_state_s = RX_START;
        end else begin
          rx_state_s = RX_IDLE;
        end
      end
      RX_START: begin
        // Mid start bit: a line back high means the edge was a glitch.
        if (rx_cnt_r == HALF_END) begin
          rx_cnt_s = '0;
          if (rx_sync2_r) begin
            rx_state_s = RX_IDLE;
          end else begin
            rx_idx_s   = '0;
            rx_perr_s  = 1'b0;
            rx_ferr_s  = 1'b0;
            rx_state_s = RX_DATA;
          end
        end else begin
          rx_state_s = RX_START;
        end
      end
      RX_DATA: begin
        if (rx_cnt_r == BIT_END) begin
          rx_cnt_s   = '0;
          rx_shift_s = {rx_sync2_r, rx_shift_r[DATA_BITS-1:1]};
          if (rx_idx_r == BIT_LAST) begin
            rx_idx_s   = '0;
            rx_state_s = (PARITY != 0) ? RX_PARITY : RX_STOP;
          end else begin
            rx_idx_s = rx_idx_r + 1'b1;
          end
        end else begin
          rx_state_s = RX_DATA;
        end
      end
      RX_PARITY: begin
        if (rx_cnt_r == BIT_END) begin
          rx_cnt_s   = '0;
          rx_idx_s   = '0;
          rx_perr_s  = (calc_parity(rx_shift_r) != rx_sync2_r);
          rx_state_s = RX_STOP;
        end else begin
          rx_state_s = RX_PARITY;
        end
      end
      RX_STOP: begin
        if (rx_cnt_r == BIT_END) begin
          rx_cnt_s  = '0;
          rx_ferr_s = rx_ferr_r | ~rx_sync2_r;
          if (rx_idx_r == STOP_LAST) begin
            rx_entry_s = {rx_ferr_s, rx_perr_r, rx_shift_r};
            if (rx_full_s) begin
              ovr_set_s = 1'b1;
            end else begin
              rx_push_s = 1'b1;
            end
            rx_state_s = RX_IDLE;
          end else begin
            rx_idx_s = rx_idx_r + 1'b1;
          end
        end else begin
          rx_state_s = RX_STOP;
        end
      end
      default: begin
        rx_cnt_s   = '0;
        rx_state_s = RX_IDLE;
      end
    endcase
  end

  // RX state register.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_r <= RX_IDLE;
      rx_cnt_r   <= '0;
      rx_idx_r   <= '0;
      rx_shift_r <= '0;
      rx_perr_r  <= 1'b0;
      rx_ferr_r  <= 1'b0;
    end else begin
      rx_state_r <= rx_state_s;
      rx_cnt_r   <= rx_cnt_s;
      rx_idx_r   <= rx_idx_s;
      rx_shift_r <= rx_shift_s;
      rx_perr_r  <= rx_perr_s;
      rx_ferr_r  <= rx_ferr_s;
    end
  end

  // Sticky overrun flag; a new drop outranks a same-cycle clear.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_overrun_r <= 1'b0;
    end else if (ovr_set_s) begin
      rx_overrun_r <= 1'b1;
    end else if (clr_overrun) begin
      rx_overrun_r <= 1'b0;
    end else begin
      rx_overrun_r <= rx_overrun_r;
    end
  end

  assign rx_overrun    = rx_overrun_r;
  assign rx_frame_err  = rx_head_s[DATA_BITS+1];
  assign rx_parity_err = rx_head_s[DATA_BITS];
  assign rx_data_out   = rx_head_s[DATA_BITS-1:0];
endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Testbench for uart_fifo_ctrl: u0 is 8N1 with 16-deep FIFOs (loopback or
// bench-driven RX), u1 is 7 data bits, even parity, 2 stop bits, 4-deep FIFOs
// (bench-driven RX). Expected RX entries are queued when stimulus is issued
// and popped by per-instance monitors whenever the DUT presents a head entry.
module tb_uart_fifo_ctrl;
  logic sys_clk = 1'b0;
  logic rst_n   = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int tests = 0;
  int fails = 0;

  // u0 signals
  logic       loop0 = 1'b1, drv0 = 1'b1;
  logic       uart_tx0, uart_rx0;
  logic       tx_wr_en0 = 1'b0, rx_rd_en0 = 1'b0, clr0 = 1'b0;
  logic [7:0] tx_data0 = 8'h00, rx_data0;
  logic       tx_full0, tx_busy0, rx_perr0, rx_ferr0, rx_empty0, rx_ovr0;
  logic [4:0] tx_level0, rx_level0;
  // u1 signals
  logic       drv1 = 1'b1;
  logic       uart_tx1;
  logic       tx_wr_en1 = 1'b0, rx_rd_en1 = 1'b0, clr1 = 1'b0;
  logic [6:0] tx_data1 = 7'h00, rx_data1;
  logic       tx_full1, tx_busy1, rx_perr1, rx_ferr1, rx_empty1, rx_ovr1;
  logic [2:0] tx_level1, rx_level1;

  assign uart_rx0 = loop0 ? uart_tx0 : drv0;

  uart_fifo_ctrl #(.CLK_FREQ_MHZ(10), .BAUD_RATE(1_000_000), .DATA_BITS(8),
                   .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH_LOG2(4)) u0 (
    .sys_clk(sys_clk), .rst_n(rst_n), .uart_rx(uart_rx0), .uart_tx(uart_tx0),
    .tx_wr_en(tx_wr_en0), .tx_data_in(tx_data0), .tx_full(tx_full0),
    .tx_level(tx_level0), .tx_busy(tx_busy0), .rx_rd_en(rx_rd_en0),
    .rx_data_out(rx_data0), .rx_parity_err(rx_perr0), .rx_frame_err(rx_ferr0),
    .rx_empty(rx_empty0), .rx_level(rx_level0), .rx_overrun(rx_ovr0),
    .clr_overrun(clr0));

  uart_fifo_ctrl #(.CLK_FREQ_MHZ(10), .BAUD_RATE(1_000_000), .DATA_BITS(7),
                   .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH_LOG2(2)) u1 (
    .sys_clk(sys_clk), .rst_n(rst_n), .uart_rx(drv1), .uart_tx(uart_tx1),
    .tx_wr_en(tx_wr_en1), .tx_data_in(tx_data1), .tx_full(tx_full1),
    .tx_level(tx_level1), .tx_busy(tx_busy1), .rx_rd_en(rx_rd_en1),
    .rx_data_out(rx_data1), .rx_parity_err(rx_perr1), .rx_frame_err(rx_ferr1),
    .rx_empty(rx_empty1), .rx_level(rx_level1), .rx_overrun(rx_ovr1),
    .clr_overrun(clr1));

  // Reference model: queues of expected RX entries {frame_err, parity_err, data}.
  logic [9:0] exp0[$];
  logic [8:0] exp1[$];
  bit         mon_en0 = 1'b1, mon_en1 = 1'b1;
  bit         ovr_exp1 = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor u0: pop and compare every entry the DUT presents.
  initial begin
    logic [9:0] got0, e0;
    forever begin
      @(negedge sys_clk);
      if (mon_en0 && rst_n && !rx_empty0) begin
        got0 = {rx_ferr0, rx_perr0, rx_data0};
        tests++;
        if (exp0.size() == 0) begin
          fails++;
          $display("FAIL rx0_unexpected: got 0x%0h expected no entry", got0);
        end else begin
          e0 = exp0.pop_front();
          if (got0 !== e0) begin
            fails++;
            $display("FAIL rx0_entry: got 0x%0h expected 0x%0h", got0, e0);
          end
        end
        rx_rd_en0 = 1'b1;
      end else begin
        rx_rd_en0 = 1'b0;
      end
    end
  end

  // Monitor u1.
  initial begin
    logic [8:0] got1, e1;
    forever begin
      @(negedge sys_clk);
      if (mon_en1 && rst_n && !rx_empty1) begin
        got1 = {rx_ferr1, rx_perr1, rx_data1};
        tests++;
        if (exp1.size() == 0) begin
          fails++;
          $display("FAIL rx1_unexpected: got 0x%0h expected no entry", got1);
        end else begin
          e1 = exp1.pop_front();
          if (got1 !== e1) begin
            fails++;
            $display("FAIL rx1_entry: got 0x%0h expected 0x%0h", got1, e1);
          end
        end
        rx_rd_en1 = 1'b1;
      end else begin
        rx_rd_en1 = 1'b0;
      end
    end
  end

  task automatic drive(input bit which, input logic v);
    if (which) drv1 = v;
    else       drv0 = v;
  endtask

  // Drive one frame, 10 clocks per bit; leaves the line at the stop value.
  task automatic send_frame(input bit which, input logic [7:0] d, input int nbits,
                            input int pmode, input bit inv_par, input int nstop,
                            input logic stop_val);
    logic p;
    drive(which, 1'b0);
    repeat (10) @(posedge sys_clk);
    p = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      p = p ^ d[i];
      drive(which, d[i]);
      repeat (10) @(posedge sys_clk);
    end
    if (pmode != 0) begin
      if (pmode == 1) p = ~p;
      drive(which, p ^ inv_par);
      repeat (10) @(posedge sys_clk);
    end
    for (int s = 0; s < nstop; s++) begin
      drive(which, stop_val);
      repeat (10) @(posedge sys_clk);
    end
  endtask

  // One u1 character: model FIFO of depth 4 holds it or records an overrun.
  task automatic rx1_char(input logic [6:0] d, input bit inv, input bit stop_err);
    if (exp1.size() < 4) exp1.push_back({stop_err, inv, d});
    else                 ovr_exp1 = 1'b1;
    send_frame(1'b1, {1'b0, d}, 7, 2, inv, 2, ~stop_err);
    drv1 = 1'b1;
    repeat (20) @(posedge sys_clk);
  endtask

  task automatic drain0(input int budget);
    int n = 0;
    while (exp0.size() != 0 && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    check("rx0_drain_remaining", 32'(exp0.size()), 32'd0);
  endtask

  task automatic drain1(input int budget);
    int n = 0;
    while (exp1.size() != 0 && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    check("rx1_drain_remaining", 32'(exp1.size()), 32'd0);
  endtask

  task automatic write0(input logic [7:0] d);
    @(negedge sys_clk);
    tx_wr_en0 = 1'b1;
    tx_data0  = d;
    exp0.push_back({2'b00, d});
    @(negedge sys_clk);
    tx_wr_en0 = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    // ---------------- reset state
    repeat (3) @(negedge sys_clk);
    check("rst_uart_tx", 32'(uart_tx0), 32'd1);
    rst_n = 1'b1;
    @(negedge sys_clk);
    check("rst_tx_busy", 32'(tx_busy0), 32'd0);
    check("rst_tx_level", 32'(tx_level0), 32'd0);
    check("rst_tx_full", 32'(tx_full0), 32'd0);
    check("rst_rx_empty", 32'(rx_empty0), 32'd1);
    check("rst_rx_level", 32'(rx_level0), 32'd0);
    check("rst_rx_overrun", 32'(rx_ovr0), 32'd0);
    check("rst_head_flags", 32'({rx_ferr0, rx_perr0}), 32'd0);
    check("rst_rx1_empty", 32'(rx_empty1), 32'd1);
    repeat (5) @(negedge sys_clk);

    // ---------------- 8N1 loopback A5, 3C: start timing and gapless frames
    tx_wr_en0 = 1'b1; tx_data0 = 8'hA5; exp0.push_back({2'b00, 8'hA5});
    @(negedge sys_clk);                       // edge k done
    check("tx_level_after_k", 32'(tx_level0), 32'd1);
    tx_data0 = 8'h3C; exp0.push_back({2'b00, 8'h3C});
    @(negedge sys_clk);                       // edge k+1
    tx_wr_en0 = 1'b0;
    check("uart_tx_k1_high", 32'(uart_tx0), 32'd1);
    @(negedge sys_clk);                       // edge k+2
    check("uart_tx_k2_low", 32'(uart_tx0), 32'd0);
    check("tx_busy_k2", 32'(tx_busy0), 32'd1);
    check("tx_level_k2", 32'(tx_level0), 32'd1);
    repeat (99) @(negedge sys_clk);           // edge k+101
    check("uart_tx_last_stop", 32'(uart_tx0), 32'd1);
    @(negedge sys_clk);                       // edge k+102
    check("uart_tx_2nd_start", 32'(uart_tx0), 32'd0);
    repeat (100) @(negedge sys_clk);          // edge k+202
    check("uart_tx_idle_after", 32'(uart_tx0), 32'd1);
    check("tx_busy_idle_after", 32'(tx_busy0), 32'd0);
    drain0(400);

    // ---------------- randomized loopback with random gaps
    for (int i = 0; i < 8; i++) begin
      write0(8'($urandom));
      repeat ($urandom_range(0, 120)) @(negedge sys_clk);
    end
    drain0(1300);

    // ---------------- break: 0x81 with stop 0, then line held low
    repeat (20) @(negedge sys_clk);
    loop0 = 1'b0;
    drv0  = 1'b1;
    repeat (20) @(posedge sys_clk);
    exp0.push_back({2'b10, 8'h81});
    send_frame(1'b0, 8'h81, 8, 0, 1'b0, 1, 1'b0);
    repeat (300) @(posedge sys_clk);
    drv0 = 1'b1;
    repeat (50) @(negedge sys_clk);
    check("break_pending", 32'(exp0.size()), 32'd0);
    check("break_rx_level", 32'(rx_level0), 32'd0);

    // ---------------- 3-clock glitch is rejected
    @(posedge sys_clk);
    drv0 = 1'b0;
    repeat (3) @(posedge sys_clk);
    drv0 = 1'b1;
    repeat (50) @(negedge sys_clk);
    check("glitch_rx_empty", 32'(rx_empty0), 32'd1);
    check("glitch_rx_level", 32'(rx_level0), 32'd0);
    loop0 = 1'b1;
    repeat (10) @(negedge sys_clk);

    // ---------------- 18 consecutive writes into a 16-deep TX FIFO
    for (int i = 1; i <= 18; i++) begin
      d = 8'($urandom);
      tx_wr_en0 = 1'b1;
      tx_data0  = d;
      if (i <= 17) exp0.push_back({2'b00, d});
      @(negedge sys_clk);
      if (i == 16) check("tx_full_edge16", 32'(tx_full0), 32'd0);
      if (i == 17) check("tx_full_edge17", 32'(tx_full0), 32'd1);
      if (i == 18) check("tx_level_edge18", 32'(tx_level0), 32'd16);
    end
    tx_wr_en0 = 1'b0;
    drain0(17 * 100 + 500);

    // ---------------- u1: 7E2, inverted parity on 0x55
    rx1_char(7'h55, 1'b1, 1'b0);
    drain1(200);

    // ---------------- u1: randomized frames with parity/stop errors
    for (int i = 0; i < 10; i++) begin
      rx1_char(7'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    end
    drain1(300);

    // ---------------- u1: overrun with 4-deep RX FIFO
    mon_en1 = 1'b0;
    repeat (3) @(posedge sys_clk);
    for (int i = 0; i < 5; i++) begin
      rx1_char(7'($urandom), 1'b0, 1'b0);
    end
    @(negedge sys_clk);
    check("ovr_rx_level", 32'(rx_level1), 32'd4);
    check("ovr_flag_set", 32'(rx_ovr1), 32'(ovr_exp1));
    clr1 = 1'b1;
    @(negedge sys_clk);
    clr1 = 1'b0;
    ovr_exp1 = 1'b0;
    check("ovr_flag_cleared", 32'(rx_ovr1), 32'(ovr_exp1));
    mon_en1 = 1'b1;
    drain1(100);
    repeat (5) @(negedge sys_clk);
    check("ovr_rx_level_drained", 32'(rx_level1), 32'd0);

    // ---------------- asynchronous reset mid TX frame
    write0(8'h0F);
    write0(8'hF0);
    write0(8'h33);
    repeat (40) @(negedge sys_clk);
    check("midframe_busy", 32'(tx_busy0), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_uart_tx", 32'(uart_tx0), 32'd1);
    check("midrst_tx_level", 32'(tx_level0), 32'd0);
    check("midrst_tx_busy", 32'(tx_busy0), 32'd0);
    exp0.delete();
    exp1.delete();
    @(negedge sys_clk);
    rst_n = 1'b1;
    repeat (200) @(negedge sys_clk);
    check("post_rst_rx_empty", 32'(rx_empty0), 32'd1);
    check("post_rst_uart_tx", 32'(uart_tx0), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
